alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu.sv | 53 +++++
 rtl/alu_sequencer.sv | 86 ++++++++
 tb/tb_alu_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: op codes, sequencer states and flag bit positions.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_XOR0 = 3'b000,
      OP_XOR1 = 3'b001,
      OP_SHL  = 3'b010,
      OP_SHR  = 3'b011,
      OP_OR   = 3'b100,
      OP_AND  = 3'b101,
      OP_XOR2 = 3'b110,
      OP_NOT  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_e;

   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_OVF   = 1;
   localparam int FLAG_NEG   = 2;
   localparam int FLAG_CARRY = 3;

endpackage

// File: rtl/alu.sv
// Combinational ALU: xor/or/and/not and logical shifts.
module alu
   import alu_pkg::*;
#(
   parameter int BITS = 8
) (
   input  op_e             op,
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   output logic [BITS-1:0] result,
   output logic [3:0]      flags
);

   // Extra bit catches the last bit shifted out; any shift >= BITS yields 0.
   logic [BITS:0] shl;
   logic [BITS:0] shr;
   logic          carry;
   logic          ovf;

   assign shl = {1'b0, a} << b;
   assign shr = {a, 1'b0} >> b;

   always_comb begin
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      unique case (op)
         OP_XOR0, OP_XOR1, OP_XOR2: result = a ^ b;
         OP_SHL: begin
            result = shl[BITS-1:0];
            carry  = shl[BITS];
            ovf    = a[BITS-1] ^ shl[BITS-1];
         end
         OP_SHR: begin
            result = shr[BITS:1];
            carry  = shr[0];
         end
         OP_OR:  result = a | b;
         OP_AND: result = a & b;
         OP_NOT: result = ~a;
         default: result = '0;
      endcase
   end

   always_comb begin
      flags             = '0;
      flags[FLAG_ZERO]  = (result == '0);
      flags[FLAG_OVF]   = ovf;
      flags[FLAG_NEG]   = result[BITS-1];
      flags[FLAG_CARRY] = carry;
   end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response wrapper around alu with an accumulator:
// IDLE accepts, EXEC computes, RESP holds the result until taken.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int BITS = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      req_op_i,
   input  logic [BITS-1:0] req_a_i,
   input  logic [BITS-1:0] req_b_i,
   input  logic            req_use_acc_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [BITS-1:0] rsp_result_o,
   output logic [3:0]      rsp_flags_o,
   output logic            busy_o
);

   state_e          state;
   op_e             op_q;
   logic [BITS-1:0] a_q;
   logic [BITS-1:0] b_q;
   logic [BITS-1:0] acc;
   logic [BITS-1:0] alu_res;
   logic [3:0]      alu_flags;
   logic [3:0]      next_flags;

   alu #(.BITS(BITS)) u_alu (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_res),
      .flags  (alu_flags)
   );

   always_comb begin
      next_flags             = '0;
      next_flags[FLAG_ZERO]  = (alu_res == '0);
      next_flags[FLAG_OVF]   = alu_flags[FLAG_OVF];
      next_flags[FLAG_NEG]   = alu_res[BITS-1];
      next_flags[FLAG_CARRY] = alu_flags[FLAG_CARRY];
   end

   assign req_ready_o = (state == S_IDLE);
   assign rsp_valid_o = (state == S_RESP);
   assign busy_o      = (state != S_IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         op_q         <= OP_XOR0;
         a_q          <= '0;
         b_q          <= '0;
         acc          <= '0;
         rsp_result_o <= '0;
         rsp_flags_o  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (req_valid_i) begin
                  op_q  <= op_e'(req_op_i);
                  a_q   <= req_use_acc_i ? acc : req_a_i;
                  b_q   <= req_b_i;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               rsp_result_o <= alu_res;
               rsp_flags_o  <= next_flags;
               acc          <= alu_res;
               state        <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready_i)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with directed vectors (BITS=8).
module tb_alu_sequencer;

   typedef struct {
      logic [7:0] res;
      logic [3:0] flags;
      logic [3:0] mask;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [2:0] req_op = 3'b000;
   logic [7:0] req_a = 8'h00;
   logic [7:0] req_b = 8'h00;
   logic       req_use_acc = 1'b0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_result;
   logic [3:0] rsp_flags;
   logic       busy;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   valid_cycles = 0;
   int   resp_count = 0;

   alu_sequencer #(.BITS(8)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_op_i      (req_op),
      .req_a_i       (req_a),
      .req_b_i       (req_b),
      .req_use_acc_i (req_use_acc),
      .rsp_valid_o   (rsp_valid),
      .rsp_ready_i   (rsp_ready),
      .rsp_result_o  (rsp_result),
      .rsp_flags_o   (rsp_flags),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Handshake one request; returns #1 after the accepting edge.
   task automatic issue(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic use_acc,
                        input logic [7:0] res, input logic [3:0] fl,
                        input logic [3:0] mask);
      exp_t e;
      int   n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      e.res = res;
      e.flags = fl;
      e.mask = mask;
      exp_q.push_back(e);
      req_op = op;
      req_a = a;
      req_b = b;
      req_use_acc = use_acc;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++)
         @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL timeout: got %0d pending responses expected 0",
                  exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int vc0;
      int rc0;
      fork
         forever begin
            @(negedge clk);
            if (!rst && rsp_valid) begin
               valid_cycles++;
               if (rsp_ready) begin
                  resp_count++;
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_rsp: got %0h expected none",
                              rsp_result);
                  end else begin
                     exp_t e;
                     e = exp_q.pop_front();
                     if (rsp_result !== e.res ||
                         (rsp_flags & e.mask) !== (e.flags & e.mask)) begin
                        errors++;
                        $display("FAIL rsp: got %0h/%b expected %0h/%b mask %b",
                                 rsp_result, rsp_flags, e.res, e.flags, e.mask);
                     end
                  end
               end
            end
         end
      join_none

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", req_ready, 1);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result", rsp_result, 0);
      chk("rst_flags", rsp_flags, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", req_ready, 1);
      @(posedge clk);
      #1;

      // AND with exact latency and single-cycle response
      vc0 = valid_cycles;
      issue(3'b101, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000, 4'b1111);
      chk("exec_valid", rsp_valid, 0);
      chk("exec_busy", busy, 1);
      chk("exec_ready", req_ready, 0);
      @(posedge clk);
      #1;
      chk("resp_valid", rsp_valid, 1);
      @(posedge clk);
      #1;
      chk("resp_drop", rsp_valid, 0);
      wait_done();
      chk("one_cycle", valid_cycles - vc0, 1);

      // Directed table
      issue(3'b110, 8'h5A, 8'h5A, 1'b0, 8'h00, 4'b0001, 4'b0101);
      wait_done();
      issue(3'b111, 8'h33, 8'h00, 1'b1, 8'hFF, 4'b0100, 4'b0101);
      wait_done();
      issue(3'b010, 8'h81, 8'h01, 1'b0, 8'h02, 4'b0000, 4'b0101);
      wait_done();
      issue(3'b010, 8'h81, 8'h09, 1'b0, 8'h00, 4'b0001, 4'b0101);
      wait_done();
      issue(3'b010, 8'h81, 8'h08, 1'b0, 8'h00, 4'b0001, 4'b0101);
      wait_done();
      issue(3'b011, 8'h80, 8'h03, 1'b0, 8'h10, 4'b0000, 4'b0101);
      wait_done();
      issue(3'b011, 8'h80, 8'h07, 1'b0, 8'h01, 4'b0000, 4'b0101);
      wait_done();
      issue(3'b011, 8'hFF, 8'h08, 1'b0, 8'h00, 4'b0001, 4'b0101);
      wait_done();
      issue(3'b000, 8'h0F, 8'hFF, 1'b0, 8'hF0, 4'b0100, 4'b0101);
      wait_done();
      issue(3'b001, 8'h00, 8'h0F, 1'b1, 8'hFF, 4'b0100, 4'b0101);
      wait_done();

      // Stall: response held, requests ignored
      rc0 = resp_count;
      rsp_ready = 1'b0;
      issue(3'b100, 8'h12, 8'h21, 1'b0, 8'h33, 4'b0000, 4'b0101);
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1;
         req_op = 3'b101;
         req_a = 8'h00;
         req_b = 8'h00;
         req_use_acc = 1'b0;
         chk("stall_valid", rsp_valid, 1);
         chk("stall_result", rsp_result, 8'h33);
         chk("stall_ready", req_ready, 0);
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      chk("stall_hold", rsp_result, 8'h33);
      rsp_ready = 1'b1;
      wait_done();
      repeat (4) @(posedge clk);
      #1;
      chk("stall_count", resp_count - rc0, 1);

      // Reset mid-EXEC discards the operation and clears acc
      rc0 = resp_count;
      issue(3'b101, 8'hFF, 8'hFF, 1'b0, 8'hFF, 4'b0100, 4'b0101);
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      #1;
      void'(exp_q.pop_back());
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_result", rsp_result, 0);
      chk("mid_rst_flags", rsp_flags, 0);
      chk("mid_rst_ready", req_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_rst_norsp", resp_count - rc0, 0);
      issue(3'b100, 8'hAA, 8'h0F, 1'b1, 8'h0F, 4'b0000, 4'b0101);
      wait_done();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
